ex_muldiv_hilo: RTL
===================

# ex_muldiv_hilo

Iterative multiply/divide unit with architectural HI/LO registers, in the EX stage directly upstream of the EX/MEM pipeline register. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It raises `busy` so the hazard unit holds IF/ID/EX while an operation is in flight. It drives the 64-bit `{HI,LO}` value that EX/MEM latches as `mult_Result_in`. A flush from the exception path (syscall/eret) aborts an in-flight operation.

## Interface
- `MUL_LATENCY`, default 3: cycles `busy` stays high for MULT/MULTU; legal range 1–8.
- `clk  input  1`: single clock, rising edge.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `start  input  1`: issue strobe from EX; sampled only in IDLE.
- `op  input  3`: operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO (package encodings).
- `rs_val  input  32`: forwarded rs operand; dividend or multiplicand.
- `rt_val  input  32`: forwarded rt operand; divisor or multiplier.
- `flush  input  1`: kills the in-flight operation.
- `busy  output  1`: operation in progress; the hazard unit stalls EX and any MFHI/MFLO.
- `done  output  1`: one-cycle pulse on the cycle after HI/LO update.
- `hi  output  32`: architectural HI.
- `lo  output  32`: architectural LO.
- `mult_result  output  64`: `{hi,lo}`, feeds EX/MEM `mult_Result_in`.

## Operation
- **States:** IDLE, MUL, DIV, SIGN.
- **IDLE, start, MTHI:** `hi<=rs_val`; `lo` unchanged; stay IDLE; no `busy`, no `done`.
- **IDLE, start, MTLO:** `lo<=rs_val`; `hi` unchanged; same rules as MTHI.
- **IDLE, start, MULT/MULTU:**
  - Latch the operands. Signed/unsigned 64-bit product.
  - Go to MUL with countdown `MUL_LATENCY-1`.
  - At count 0: write `{hi,lo}<=product`, pulse `done`, return to IDLE.
- **IDLE, start, DIV/DIVU, `rt_val`≠0:**
  - Latch absolute values (DIV) or raw values (DIVU). Record quotient sign = `rs[31]^rt[31]` and remainder sign = `rs[31]`, both forced 0 for DIVU.
  - DIV state: 32 restoring iterations, one quotient bit per cycle, MSB first.
  - Then SIGN: negate quotient and/or remainder per the recorded signs.
  - Write `lo<=quotient`, `hi<=remainder`, pulse `done`, go IDLE.
- **Divide by zero:** skip iteration. Go straight to SIGN with `lo<=32'hFFFF_FFFF`, `hi<=rs_val` (no sign fix-up).
- **Overflow, DIV 0x8000_0000 / −1:** result falls out of the magnitude algorithm as `lo=0x8000_0000`, `hi=0`. No special case.
- **Busy:** `busy` = (state≠IDLE). Combinational from the state register.
- **start while busy:** ignored. The bench asserts this never happens.
- **flush:** in any state, next state is IDLE. HI/LO keep their pre-operation values and no `done` is issued.
- **flush and start in the same cycle:** flush wins; nothing is issued, including MTHI/MTLO.

## Timing
- **Reset values:** `hi=0`, `lo=0`, `mult_result=0`, `busy=0`, `done=0`, state IDLE, internal operand/remainder registers 0. Reset asserted mid-operation aborts it immediately (asynchronous).
- **MULT/MULTU latency:** `busy` high for exactly `MUL_LATENCY` cycles after the start edge. HI/LO valid and `done`=1 on the following cycle.
- **DIV/DIVU latency:** `busy` high for 33 cycles (32 iterate + 1 SIGN); HI/LO valid on cycle 34.
- **Divide by zero:** `busy` high for 1 cycle.
- **MTHI/MTLO:** HI/LO updated at the start edge. The next instruction's MFHI/MFLO reads the new value with no stall.
- `mult_result` is always equal to `{hi,lo}` and is never independently registered.

## Structure
- **Package `muldiv_pkg`:** `op` encodings (3-bit enum), state enum, constant `DIV_ITERS=32`.
- **Sub-module `div_iter`:** one restoring-division step, combinational. Inputs: partial remainder, divisor, dividend bit. Outputs: next remainder, quotient bit. The FSM, counters, sign handling and HI/LO live in the top module.

## Test plan
- Reset: `rst_n` low → `hi=lo=0`, `busy=0`. MTHI `0x1234` then MTLO `0x5678` → `mult_result=0x00001234_00005678`, `busy` never high.
- MULT −3×5 with `MUL_LATENCY=3` → `busy` 3 cycles, then `hi=0xFFFFFFFF`, `lo=0xFFFFFFF1`, one `done` pulse. MULTU `0xFFFFFFFF×0xFFFFFFFF` → `hi=0xFFFFFFFE`, `lo=0x00000001`.
- DIVU 100/7 → `busy` 33 cycles, `lo=14`, `hi=2`. DIV −7/2 → `lo=0xFFFFFFFD`, `hi=0xFFFFFFFF`.
- DIV `0x80000000` / `0xFFFFFFFF` → `lo=0x80000000`, `hi=0`. DIVU 9/0 → `busy` 1 cycle, `lo=0xFFFFFFFF`, `hi=9`.
- DIV started with prior `hi=0xAA`, `lo=0xBB`; flush on iteration 10 → IDLE next cycle, `hi=0xAA`, `lo=0xBB`, no `done`. Flush coincident with MTLO start → `lo` unchanged.
- `rst_n` pulsed low mid-MULT → immediately `busy=0` and `hi=lo=0`. A start issued while `busy` fires the assertion and leaves HI/LO unaffected.

Source files
------------

// File: rtl/ex_muldiv_hilo_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcode and
// state encodings, iteration count and a magnitude helper.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_SIGN = 2'd3
    } state_e;

    // Two's-complement magnitude; 0x8000_0000 maps to itself, which the
    // unsigned divider treats as 2^31.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (-x) : x;
    endfunction

endpackage

// File: rtl/ex_muldiv_hilo_if.sv
// Issue/result bundle between EX and the mul/div unit.
//   master: drives start, op, rs_val, rt_val, flush; sees busy, done, hi, lo, mult_result
//   slave : the mul/div unit
interface ex_muldiv_hilo_if;

    logic               start;
    muldiv_pkg::op_e    op;
    logic [31:0]        rs_val;
    logic [31:0]        rt_val;
    logic               flush;
    logic               busy;
    logic               done;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [63:0]        mult_result;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, done, hi, lo, mult_result
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, done, hi, lo, mult_result
    );

endinterface

// File: rtl/ex_muldiv_hilo_div_iter.sv
// One restoring-division step, purely combinational.
//   rem_in       : partial remainder (always < divisor)
//   divisor      : divisor magnitude
//   dividend_bit : next dividend bit, MSB first
//   rem_out_c    : next partial remainder
//   q_bit_c      : quotient bit produced by this step
module div_iter
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN-1:0] rem_out_c,
    output logic            q_bit_c
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The shifted remainder needs one extra bit before the trial subtract.
    assign shifted   = {rem_in, dividend_bit};
    assign diff      = shifted - {1'b0, divisor};
    assign q_bit_c   = (shifted >= {1'b0, divisor});
    assign rem_out_c = q_bit_c ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv_hilo.sv
// Iterative multiply/divide unit holding architectural HI/LO.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ex_muldiv_hilo_if (issue, flush, busy/done, HI/LO)
// MULT/MULTU hold busy for MUL_LATENCY cycles; DIV/DIVU take 32 restoring
// iterations plus one sign fix-up cycle; MTHI/MTLO write in the issue cycle.
module ex_muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    ex_muldiv_hilo_if.slave    bus
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [XLEN-1:0]    hi_q;
    logic [XLEN-1:0]    lo_q;
    // quo_q/dvsr_q hold the multiplicand/multiplier during MUL and the
    // dividend-shifting-into-quotient/divisor during DIV.
    logic [XLEN-1:0]    quo_q;
    logic [XLEN-1:0]    dvsr_q;
    logic [XLEN-1:0]    rem_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               mul_signed_q;
    logic               done_q;

    logic               div_signed_c;
    logic [XLEN-1:0]    rs_mag_c;
    logic [XLEN-1:0]    rt_mag_c;
    logic [XLEN-1:0]    rem_nxt_c;
    logic               q_bit_c;
    logic [2*XLEN-1:0]  mul_a_c;
    logic [2*XLEN-1:0]  mul_b_c;
    logic [2*XLEN-1:0]  product_c;

    // Operand preparation at issue.
    assign div_signed_c = (bus.op == OP_DIV);
    assign rs_mag_c     = div_signed_c ? abs_val(bus.rs_val) : bus.rs_val;
    assign rt_mag_c     = div_signed_c ? abs_val(bus.rt_val) : bus.rt_val;

    // Extending to 64 bits makes one multiply serve both signed and unsigned.
    assign mul_a_c   = mul_signed_q ? {{XLEN{quo_q[XLEN-1]}}, quo_q}   : {{XLEN{1'b0}}, quo_q};
    assign mul_b_c   = mul_signed_q ? {{XLEN{dvsr_q[XLEN-1]}}, dvsr_q} : {{XLEN{1'b0}}, dvsr_q};
    assign product_c = mul_a_c * mul_b_c;

    div_iter u_div_iter (
        .rem_in       (rem_q),
        .divisor      (dvsr_q),
        .dividend_bit (quo_q[XLEN-1]),
        .rem_out_c    (rem_nxt_c),
        .q_bit_c      (q_bit_c)
    );

    // Control FSM with HI/LO and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            quo_q        <= '0;
            dvsr_q       <= '0;
            rem_q        <= '0;
            q_neg_q      <= 1'b0;
            r_neg_q      <= 1'b0;
            mul_signed_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                // Abort: HI/LO are only written on completion, so they keep
                // their pre-operation values.
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                OP_MTHI: hi_q <= bus.rs_val;
                                OP_MTLO: lo_q <= bus.rs_val;
                                OP_MULT, OP_MULTU: begin
                                    quo_q        <= bus.rs_val;
                                    dvsr_q       <= bus.rt_val;
                                    mul_signed_q <= (bus.op == OP_MULT);
                                    cnt_q        <= CNT_W'(MUL_LATENCY - 1);
                                    state_q      <= ST_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    if (bus.rt_val == '0) begin
                                        quo_q   <= '1;
                                        rem_q   <= bus.rs_val;
                                        q_neg_q <= 1'b0;
                                        r_neg_q <= 1'b0;
                                        state_q <= ST_SIGN;
                                    end else begin
                                        quo_q   <= rs_mag_c;
                                        dvsr_q  <= rt_mag_c;
                                        rem_q   <= '0;
                                        q_neg_q <= div_signed_c & (bus.rs_val[XLEN-1] ^ bus.rt_val[XLEN-1]);
                                        r_neg_q <= div_signed_c & bus.rs_val[XLEN-1];
                                        cnt_q   <= CNT_W'(DIV_ITERS - 1);
                                        state_q <= ST_DIV;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        if (cnt_q == '0) begin
                            hi_q    <= product_c[2*XLEN-1:XLEN];
                            lo_q    <= product_c[XLEN-1:0];
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_DIV: begin
                        // Dividend shifts out of the top as quotient bits enter the bottom.
                        rem_q <= rem_nxt_c;
                        quo_q <= {quo_q[XLEN-2:0], q_bit_c};
                        if (cnt_q == '0) begin
                            state_q <= ST_SIGN;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_SIGN: begin
                        lo_q    <= q_neg_q ? (-quo_q) : quo_q;
                        hi_q    <= r_neg_q ? (-rem_q) : rem_q;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.mult_result = {hi_q, lo_q};

endmodule
